// File: rtl/burst_pkg.sv
// rtl/burst_pkg.sv - shared FSM state encoding and transfer-mode constants for burst_addr_seq
package burst_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic MODE_SINGLE = 1'b0;
   localparam logic MODE_BURST  = 1'b1;

endpackage

// File: rtl/burst_addr_counter.sv
// rtl/burst_addr_counter.sv - loadable word-address incrementer and remaining-words down-counter
module burst_addr_counter
#(
   parameter int ADDR_W = 16,
   parameter int BLEN_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [BLEN_W-1:0] load_cnt,
   output logic [ADDR_W-1:0] addr,
   output logic [BLEN_W-1:0] remaining
);

   localparam logic [ADDR_W-1:0] ONE_ADDR = ADDR_W'(1);
   localparam logic [BLEN_W-1:0] ONE_CNT  = BLEN_W'(1);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BLEN_W-1:0] remaining_q, remaining_d;

   // Load wins over step; the address wraps naturally modulo 2^ADDR_W.
   always_comb begin
      addr_d      = addr_q;
      remaining_d = remaining_q;
      if (load) begin
         addr_d      = load_addr;
         remaining_d = load_cnt;
      end else if (step) begin
         addr_d      = addr_q + ONE_ADDR;
         remaining_d = remaining_q - ONE_CNT;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         addr_q      <= '0;
         remaining_q <= '0;
      end else begin
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
      end
   end

   assign addr      = addr_q;
   assign remaining = remaining_q;

endmodule

// File: rtl/burst_addr_seq.sv
// rtl/burst_addr_seq.sv - MRAM burst word-address sequencer FSM; BURST_BOUNDARY_CHK_EN enables end-of-space start rejection
module burst_addr_seq
   import burst_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int BLEN_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              mode_sel,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [BLEN_W-1:0] burst_len,
   output logic              addr_valid,
   input  logic              addr_ready,
   output logic [ADDR_W-1:0] addr_out,
   output logic              addr_last,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [BLEN_W-1:0] xfer_cnt,
   output logic              err
);

   localparam logic [BLEN_W-1:0] ONE_CNT = BLEN_W'(1);
   localparam logic [BLEN_W-1:0] TWO_CNT = BLEN_W'(2);

   state_t            state_q, state_d;
   logic              addr_valid_q, addr_valid_d;
   logic              addr_last_q, addr_last_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              aborted_q, aborted_d;
   logic [BLEN_W-1:0] xfer_cnt_q, xfer_cnt_d;

   logic [BLEN_W-1:0] word_cnt;
   logic [BLEN_W-1:0] remaining;
   logic              cnt_load, cnt_step;
   logic              start_req, accept_start, out_of_range;

   assign word_cnt  = (mode_sel == MODE_SINGLE) ? ONE_CNT : burst_len;
   assign start_req = (state_q == ST_IDLE) && start && en;

`ifdef BURST_BOUNDARY_CHK_EN
   localparam int EXT_W = ADDR_W + BLEN_W + 1;
   logic [EXT_W-1:0] last_word_ext;
   logic             err_q, err_d;

   // Zero-length bursts issue nothing, so they can never cross the top of the space.
   always_comb begin
      last_word_ext = EXT_W'(start_addr) + EXT_W'(word_cnt) - EXT_W'(1);
      out_of_range  = (word_cnt != '0) && (last_word_ext > EXT_W'({ADDR_W{1'b1}}));
   end

   always_comb begin
      err_d = start_req && out_of_range;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign out_of_range = 1'b0;
   assign err          = 1'b0;
`endif

   assign accept_start = start_req && !out_of_range;

   always_comb begin
      state_d      = state_q;
      addr_valid_d = addr_valid_q;
      addr_last_d  = addr_last_q;
      done_d       = 1'b0;
      aborted_d    = 1'b0;
      xfer_cnt_d   = xfer_cnt_q;
      cnt_load     = 1'b0;
      cnt_step     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept_start) begin
               cnt_load   = 1'b1;
               xfer_cnt_d = '0;
               if (word_cnt == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d      = ST_ISSUE;
                  addr_valid_d = 1'b1;
                  addr_last_d  = (word_cnt == ONE_CNT);
               end
            end
         end

         // Abort outranks a same-cycle handshake: that word is dropped, not counted.
         ST_ISSUE: begin
            if (abort) begin
               state_d      = ST_IDLE;
               addr_valid_d = 1'b0;
               addr_last_d  = 1'b0;
               aborted_d    = 1'b1;
            end else if (addr_valid_q && addr_ready) begin
               cnt_step   = 1'b1;
               xfer_cnt_d = xfer_cnt_q + ONE_CNT;
               if (remaining == ONE_CNT) begin
                  state_d      = ST_DONE;
                  addr_valid_d = 1'b0;
                  addr_last_d  = 1'b0;
                  done_d       = 1'b1;
               end else begin
                  addr_last_d = (remaining == TWO_CNT);
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d      = ST_IDLE;
            addr_valid_d = 1'b0;
            addr_last_d  = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         addr_valid_q <= 1'b0;
         addr_last_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         xfer_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         addr_valid_q <= addr_valid_d;
         addr_last_q  <= addr_last_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         aborted_q    <= aborted_d;
         xfer_cnt_q   <= xfer_cnt_d;
      end
   end

   burst_addr_counter #(
      .ADDR_W (ADDR_W),
      .BLEN_W (BLEN_W)
   ) u_counter (
      .clk       (clk),
      .rst       (rst),
      .load      (cnt_load),
      .step      (cnt_step),
      .load_addr (start_addr),
      .load_cnt  (word_cnt),
      .addr      (addr_out),
      .remaining (remaining)
   );

   assign addr_valid = addr_valid_q;
   assign addr_last  = addr_last_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign aborted    = aborted_q;
   assign xfer_cnt   = xfer_cnt_q;

endmodule

// File: tb/tb_burst_addr_seq.sv
// tb/tb_burst_addr_seq.sv - scoreboard bench for burst_addr_seq (expects BURST_BOUNDARY_CHK_EN to match the RTL build)
module tb_burst_addr_seq;

   localparam int EV_DONE    = 1;
   localparam int EV_ABORTED = 2;
   localparam int EV_ERR     = 3;

   typedef struct {
      logic [15:0] addr;
      logic        last;
   } beat_t;

   typedef struct {
      int kind;
      int cnt;
   } evt_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b1;
   logic        mode_sel = 1'b0;
   logic        start = 1'b0;
   logic [15:0] start_addr = '0;
   logic [7:0]  burst_len = '0;
   logic        addr_ready = 1'b0;
   logic        abort = 1'b0;
   logic        addr_valid;
   logic [15:0] addr_out;
   logic        addr_last;
   logic        busy;
   logic        done;
   logic        aborted;
   logic [7:0]  xfer_cnt;
   logic        err;

   int checks = 0;
   int errors = 0;

   beat_t exp_beats[$];
   evt_t  exp_evts[$];

   logic        hold_pending = 1'b0;
   logic [15:0] hold_addr = '0;

   burst_addr_seq #(.ADDR_W(16), .BLEN_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .mode_sel   (mode_sel),
      .start      (start),
      .start_addr (start_addr),
      .burst_len  (burst_len),
      .addr_valid (addr_valid),
      .addr_ready (addr_ready),
      .addr_out   (addr_out),
      .addr_last  (addr_last),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .xfer_cnt   (xfer_cnt),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_beat(input logic [15:0] a, input logic l);
      beat_t b;
      b.addr = a;
      b.last = l;
      exp_beats.push_back(b);
   endtask

   task automatic push_evt(input int kind, input int cnt);
      evt_t e;
      e.kind = kind;
      e.cnt  = cnt;
      exp_evts.push_back(e);
   endtask

   task automatic handle_evt(input int kind);
      evt_t e;
      if (exp_evts.size() == 0) begin
         check("unexpected_pulse", 32'(kind), 32'd0);
      end else begin
         e = exp_evts.pop_front();
         check("pulse_kind", 32'(kind), 32'(e.kind));
         if (e.cnt >= 0) check("pulse_xfer_cnt", 32'(xfer_cnt), 32'(e.cnt));
      end
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      beat_t b;
      if (rst) begin
         if (addr_valid) begin
            if (hold_pending) check("addr_stable", 32'(addr_out), 32'(hold_addr));
            hold_pending = !addr_ready;
            hold_addr    = addr_out;
         end else begin
            hold_pending = 1'b0;
         end
         if (addr_valid && addr_ready && !abort) begin
            if (exp_beats.size() == 0) begin
               check("unexpected_beat", 32'(addr_out), 32'hFFFF_FFFF);
            end else begin
               b = exp_beats.pop_front();
               check("beat_addr", 32'(addr_out), 32'(b.addr));
               check("beat_last", 32'(addr_last), 32'(b.last));
            end
         end
         if (done)    handle_evt(EV_DONE);
         if (aborted) handle_evt(EV_ABORTED);
         if (err)     handle_evt(EV_ERR);
      end else begin
         hold_pending = 1'b0;
      end
   end

   task automatic start_xfer(input logic m, input logic [15:0] a, input logic [7:0] len);
      @(posedge clk);
      #1;
      mode_sel   = m;
      start_addr = a;
      burst_len  = len;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(busy), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_addr_valid"}, 32'(addr_valid), 32'd0);
      check({tag, "_addr_out"},   32'(addr_out),   32'd0);
      check({tag, "_addr_last"},  32'(addr_last),  32'd0);
      check({tag, "_busy"},       32'(busy),       32'd0);
      check({tag, "_done"},       32'(done),       32'd0);
      check({tag, "_aborted"},    32'(aborted),    32'd0);
      check({tag, "_xfer_cnt"},   32'(xfer_cnt),   32'd0);
      check({tag, "_err"},        32'(err),        32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;

      // Single transfer ignores burst_len, then a back-to-back start on the first IDLE cycle.
      addr_ready = 1'b1;
      push_beat(16'h0100, 1'b1);
      push_evt(EV_DONE, 1);
      start_xfer(1'b0, 16'h0100, 8'd9);
      @(negedge clk);
      check("single_valid_latency", 32'(addr_valid), 32'd1);
      check("single_addr", 32'(addr_out), 32'h0100);
      @(posedge clk);
      @(posedge clk);
      #1;
      push_beat(16'h0105, 1'b1);
      push_evt(EV_DONE, 1);
      mode_sel   = 1'b0;
      start_addr = 16'h0105;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("b2b_valid", 32'(addr_valid), 32'd1);
      check("b2b_addr", 32'(addr_out), 32'h0105);
      wait_idle("b2b_idle");

      // Burst with alternating backpressure.
      push_beat(16'h0010, 1'b0);
      push_beat(16'h0011, 1'b0);
      push_beat(16'h0012, 1'b0);
      push_beat(16'h0013, 1'b1);
      push_evt(EV_DONE, 4);
      addr_ready = 1'b0;
      start_xfer(1'b1, 16'h0010, 8'd4);
      addr_ready = 1'b1;
      for (int i = 0; i < 40 && busy; i++) begin
         @(posedge clk);
         #1;
         addr_ready = ~addr_ready;
      end
      addr_ready = 1'b1;
      wait_idle("bp_idle");
      check("bp_xfer_cnt", 32'(xfer_cnt), 32'd4);

      // start with en=0 is ignored.
      en = 1'b0;
      start_xfer(1'b1, 16'h0400, 8'd3);
      @(negedge clk);
      check("en0_busy", 32'(busy), 32'd0);
      check("en0_valid", 32'(addr_valid), 32'd0);
      en = 1'b1;

      // Zero-length burst: done one cycle after start, nothing issued.
      push_evt(EV_DONE, 0);
      start_xfer(1'b1, 16'h0500, 8'd0);
      @(negedge clk);
      check("zero_done", 32'(done), 32'd1);
      check("zero_valid", 32'(addr_valid), 32'd0);
      wait_idle("zero_idle");

      // Abort together with the handshake of the third word.
      push_beat(16'h0200, 1'b0);
      push_beat(16'h0201, 1'b0);
      push_evt(EV_ABORTED, 2);
      start_xfer(1'b1, 16'h0200, 8'd8);
      repeat (2) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_valid", 32'(addr_valid), 32'd0);
      check("abort_xfer_cnt", 32'(xfer_cnt), 32'd2);
      repeat (2) @(negedge clk);

      // Top-of-space start: wraps by default, rejected with the boundary check.
`ifdef BURST_BOUNDARY_CHK_EN
      push_evt(EV_ERR, -1);
      start_xfer(1'b1, 16'hFFFE, 8'd4);
      @(negedge clk);
      check("reject_valid", 32'(addr_valid), 32'd0);
      check("reject_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
`else
      push_beat(16'hFFFE, 1'b0);
      push_beat(16'hFFFF, 1'b0);
      push_beat(16'h0000, 1'b0);
      push_beat(16'h0001, 1'b1);
      push_evt(EV_DONE, 4);
      start_xfer(1'b1, 16'hFFFE, 8'd4);
      wait_idle("wrap_idle");
`endif

      // Start while busy is ignored, then reset during word 2 of 5.
      push_beat(16'h0300, 1'b0);
      start_xfer(1'b1, 16'h0300, 8'd5);
      start_addr = 16'h0777;
      burst_len  = 8'd3;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
      check("busy_start_addr", 32'(addr_out), 32'h0301);
      check("busy_start_cnt", 32'(xfer_cnt), 32'd1);
      @(negedge clk);
      check_all_zero("midreset");
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("midreset_busy", 32'(busy), 32'd0);

      check("beats_drained", 32'(exp_beats.size()), 32'd0);
      check("events_drained", 32'(exp_evts.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/burst_addr_seq.md
BURST_ADDR_SEQ -- requirements
Module: burst_addr_seq

Interface
REQ-001 Parameter ADDR_W, default 16: width of the MRAM word address.
REQ-002 Parameter BLEN_W, default 8: width of the burst length, in words.
REQ-003 Port clk, in, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, in, 1: synchronous, active-low reset.
REQ-005 Port en, in, 1: enables acceptance of start.
REQ-006 Port mode_sel, in, 1: 0 = single transfer, 1 = burst.
REQ-007 Port start, in, 1: one-cycle request to begin a transfer.
REQ-008 Port start_addr, in, ADDR_W: first word address.
REQ-009 Port burst_len, in, BLEN_W: number of words in the burst.
REQ-010 Port addr_valid, out, 1: addr_out is presented to the downstream serializer.
REQ-011 Port addr_ready, in, 1: downstream accepts addr_out.
REQ-012 Port addr_out, out, ADDR_W: current word address.
REQ-013 Port addr_last, out, 1: addr_out is the final word of the transfer.
REQ-014 Port abort, in, 1: cancels an in-flight transfer.
REQ-015 Port busy, out, 1: high in any state other than IDLE.
REQ-016 Port done, out, 1: one-cycle pulse on normal completion.
REQ-017 Port aborted, out, 1: one-cycle pulse on abort.
REQ-018 Port xfer_cnt, out, BLEN_W: words handshaken in the current or last transfer.
REQ-019 Port err, out, 1: one-cycle pulse on a rejected start; tied 0 unless BURST_BOUNDARY_CHK_EN is defined.

Function
REQ-020 The FSM SHALL have the states IDLE, ISSUE and DONE, and all outputs SHALL be registered.
REQ-021 In IDLE, start&en SHALL latch start_addr and the word count into internal registers, clear xfer_cnt and move to ISSUE; addr_valid SHALL rise on the next cycle (1-cycle latency).
REQ-022 When mode_sel=0, the word count SHALL be forced to 1 and burst_len ignored.
REQ-023 When mode_sel=1 and burst_len=0, the block SHALL go IDLE→DONE with no address issued; done SHALL pulse and xfer_cnt SHALL stay 0.
REQ-024 In ISSUE, addr_valid SHALL stay 1 and addr_out stable until addr_valid&addr_ready.
REQ-025 On each handshake, xfer_cnt SHALL increment, remaining SHALL decrement and addr_out SHALL increment by 1 modulo 2^ADDR_W.
REQ-026 addr_last SHALL be 1 exactly when remaining=1.
REQ-027 A handshake with remaining=1 SHALL move the FSM to DONE and drop addr_valid on the next cycle.
REQ-028 DONE SHALL last one cycle, with done=1, then return to IDLE.
REQ-029 start SHALL be ignored while busy; start with en=0 SHALL be ignored.
REQ-030 abort in ISSUE SHALL take priority over a simultaneous handshake: that handshake is not counted, the FSM goes to IDLE, aborted pulses once and done does not assert.
REQ-031 abort in IDLE or DONE SHALL have no effect.
REQ-032 Back-to-back transfers SHALL be possible: start may be accepted on the first IDLE cycle after DONE.

Reset
REQ-033 With rst=0 at a clock edge, the FSM SHALL enter IDLE and all outputs and internal registers SHALL clear to 0, including mid-burst.
REQ-034 No done or aborted pulse SHALL be produced by reset.

Configuration
REQ-035 With BURST_BOUNDARY_CHK_EN defined, a start whose start_addr+count-1 exceeds 2^ADDR_W-1 SHALL be rejected: err pulses on the next cycle, the FSM stays IDLE and nothing is issued.
REQ-036 Without BURST_BOUNDARY_CHK_EN, addresses SHALL wrap modulo 2^ADDR_W and err SHALL be constant 0.

Structure
REQ-037 The FSM state encoding and the MODE_SINGLE=0 / MODE_BURST=1 constants SHALL reside in the shared package burst_pkg.
REQ-038 The loadable address incrementer and remaining down-counter SHALL be one sub-module, burst_addr_counter; the FSM stays in burst_addr_seq.

Verification
REQ-039 Single transfer: mode_sel=0, start_addr=0x0100, burst_len=9, addr_ready=1 -> exactly one handshake at 0x0100 with addr_last=1, done pulses, xfer_cnt=1.
REQ-040 Burst with backpressure: start_addr=0x0010, burst_len=4, addr_ready toggling 1/0 -> addresses 0x10, 0x11, 0x12, 0x13 each held stable while not ready, addr_last only on 0x13, done pulses, xfer_cnt=4.
REQ-041 Zero length: mode_sel=1, burst_len=0 -> no addr_valid, done pulses one cycle after start, xfer_cnt=0.
REQ-042 Abort and handshake together: burst_len=8, abort and handshake in the same cycle on the 3rd word -> aborted pulses, xfer_cnt=2, FSM returns to IDLE, no done.
REQ-043 Wrap or reject: start_addr=0xFFFE, burst_len=4 -> without the macro, addresses FFFE, FFFF, 0000, 0001; with BURST_BOUNDARY_CHK_EN, err pulses and addr_valid stays 0.
REQ-044 Reset mid-burst and ignored start: rst=0 during word 2 of 5 -> all outputs 0 on the next edge, no pulses; start asserted while busy -> no effect.
